pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It watches the ID, EX and MEM stages and drives enable/clear controls into the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It covers three hazard sources:
- load-use hazards;
- taken-branch redirects;
- multi-cycle data-memory accesses, with a timeout that raises a sticky error.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- TIMEOUT, 15: maximum consecutive data-memory wait cycles before the error state; 0 disables the timeout.
- CNT_W, 32: performance counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; everything samples on posedge.
- reset  in  1  synchronous, active-high reset.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_Reg_Rd  in  5  destination register of the instruction in EX.
- IF_ID_Reg_Rs1, IF_ID_Reg_Rs2  in  5 each  source registers of the instruction in ID.
- branch_taken_E  in  1  branch or jump resolved taken in EX.
- dmem_req_M  in  1  the MEM-stage instruction accesses data memory (MemRead or MemWrite).
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- flush_D, flush_E  out  1 each  clear IF/ID and ID/EX to a bubble (RegWrite and MemWrite forced to 0).
- bubble_W  out  1  load a bubble into MEM/WB (RegWriteW forced to 0).
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cycles, flush_count  out  CNT_W each  performance counters.

## Operation
- FSM states:
  - RUN
  - MEM_WAIT
  - ERROR
- Registered state: FSM state, wait_cnt[4:0], both counters, mem_err.
- Control outputs are combinational from the inputs and the state.

Signal definitions:
- mem_stall = dmem_req_M && !dmem_ready, or state == ERROR.
- load_use = ID_EX_MemRead && ID_EX_Reg_Rd != 0 && (ID_EX_Reg_Rd == IF_ID_Reg_Rs1 || ID_EX_Reg_Rd == IF_ID_Reg_Rs2).

Priority, highest first:
1. **mem_stall:** stall_F, stall_D, stall_E, stall_M = 1 and bubble_W = 1. flush_D and flush_E are forced to 0, because EX is frozen and its branch is re-evaluated later.
2. **branch_taken_E:** flush_D = 1 and flush_E = 1. The load-use stall is suppressed.
3. **load_use:** stall_F = 1, stall_D = 1, flush_E = 1.
4. **Otherwise:** all control outputs are 0.

FSM transitions:
- RUN to MEM_WAIT when dmem_req_M && !dmem_ready; wait_cnt is set to 1.
- MEM_WAIT to RUN when dmem_ready = 1 or dmem_req_M = 0; wait_cnt is cleared.
- In MEM_WAIT, wait_cnt increments on each further !dmem_ready cycle.
- If TIMEOUT != 0 and wait_cnt == TIMEOUT with dmem_ready still low, the FSM moves to ERROR and mem_err is set.
- ERROR is left only by reset.

Counters:
- stall_cycles increments in any cycle where any stall_* output is 1.
- flush_count increments in any cycle where flush_D or flush_E is 1; a cycle asserting both counts once.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset values:
  - FSM state RUN, wait_cnt 0.
  - stall_cycles 0, flush_count 0, mem_err 0.
  - While reset is high, every stall/flush/bubble output is 0; the stage registers clear themselves.
- Latency: control outputs have zero-cycle latency; they are valid in the same cycle as the causing inputs.
- State, counter and flag updates appear one cycle later.
- Memory handshake: the pipeline is frozen in every cycle where dmem_ready is low. In the cycle dmem_ready goes high, all stalls are 0 and the pipeline advances.
- A load-use stall lasts exactly 1 cycle; the next cycle sees the bubble in EX.
- Simultaneous events:
  - mem_stall with branch_taken_E: freeze only; the flush occurs in the first cycle after the wait.
  - branch_taken_E with load_use: flush only, no stall.
- Reset during MEM_WAIT or ERROR returns to RUN on the next edge.
- Width rule: wait_cnt is 5 bits, so TIMEOUT is at most 31.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - REG_X0 = 5'd0;
  - the default TIMEOUT.
- Sub-module load_use_detect (purely combinational): computes load_use from ID_EX_MemRead, ID_EX_Reg_Rd, IF_ID_Reg_Rs1 and IF_ID_Reg_Rs2.
- The FSM, priority logic and counters live in the top module.

## Test plan
- **Load-use hit:** ID_EX_MemRead = 1, Rd = 5, Rs1 = 5 → in that cycle stall_F = stall_D = flush_E = 1; next cycle all controls 0. With Rd = 0, no stall.
- **Taken branch together with load-use:** branch_taken_E = 1 in the same cycle as a load-use hit → flush_D = flush_E = 1, stall_F = 0, flush_count increments by exactly 1.
- **3-cycle memory wait:** dmem_req_M = 1 with dmem_ready low for 3 cycles → all four stalls and bubble_W high for exactly 3 cycles; state MEM_WAIT; stall_cycles = 3; return to RUN once ready.
- **Branch during memory wait:** branch_taken_E = 1 throughout a 2-cycle wait → no flush during the wait; flush_D = flush_E = 1 on the first post-wait cycle.
- **Timeout:** TIMEOUT = 4, dmem_ready held low → mem_err = 1 after 5 wait cycles; stalls stay asserted even once dmem_ready goes high; reset clears mem_err and returns to RUN.
- **Counter wrap:** CNT_W = 4 with 17 stall cycles → stall_cycles = 1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0          = 5'd0;
  localparam int         TIMEOUT_DEFAULT = 15;
  localparam int         WAIT_W          = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: a load in EX whose destination feeds a source of the
// instruction in ID. Writes to x0 never create a dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_reg_rd,
  input  logic [4:0] if_id_reg_rs1,
  input  logic [4:0] if_id_reg_rs2,
  output logic       load_use
);

  assign load_use = id_ex_mem_read && (id_ex_reg_rd != REG_X0) &&
                    ((id_ex_reg_rd == if_id_reg_rs1) || (id_ex_reg_rd == if_id_reg_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory wait freezes with a sticky timeout error.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Reg_Rd,
  input  logic [4:0]       IF_ID_Reg_Rs1,
  input  logic [4:0]       IF_ID_Reg_Rs2,
  input  logic             branch_taken_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             bubble_W,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]    flush_count_q, flush_count_d;

  logic load_use;
  logic mem_wait_now;
  logic mem_stall;
  logic any_stall;
  logic any_flush;

  load_use_detect u_load_use_detect (
    .id_ex_mem_read (ID_EX_MemRead),
    .id_ex_reg_rd   (ID_EX_Reg_Rd),
    .if_id_reg_rs1  (IF_ID_Reg_Rs1),
    .if_id_reg_rs2  (IF_ID_Reg_Rs2),
    .load_use       (load_use)
  );

  assign mem_wait_now = dmem_req_M && !dmem_ready;
  assign mem_stall    = mem_wait_now || (state_q == ERROR);

  // A frozen EX keeps its branch, so the flush is deferred until the wait ends.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    bubble_W = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        stall_M  = 1'b1;
        bubble_W = 1'b1;
      end else if (branch_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  assign any_stall = stall_F || stall_D || stall_E || stall_M;
  assign any_flush = flush_D || flush_E;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, any_stall};
    flush_count_d  = flush_count_q  + {{(CNT_W-1){1'b0}}, any_flush};
    unique case (state_q)
      RUN: begin
        if (mem_wait_now) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !dmem_req_M) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_CNT)) begin
          state_d   = ERROR;
          mem_err_d = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
